// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle between a source/consumer (master) and alu_seq (slave)
interface alu_seq_if #(parameter int WIDTH = 8);
    logic in_valid, in_ready, acc_sel, out_valid, out_ready, carry, zero, busy;
    logic [3:0] op;
    logic [WIDTH-1:0] a, b, result;
    modport master (
        output in_valid, op, a, b, acc_sel, out_ready,
        input in_ready, out_valid, result, carry, zero, busy
    );
    modport slave (
        input in_valid, op, a, b, acc_sel, out_ready,
        output in_ready, out_valid, result, carry, zero, busy
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered handshake ALU with accumulator and flags; define ALU_MUL_EN for the shift-add multiply on op 8
module alu_seq #(parameter int WIDTH = 8) (
    input logic clk,
    input logic rst_n,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] acc, opa, res, fin_res;
    logic [WIDTH:0] add_w, sub_ab, sub_ba;
    logic c, fin_c, take, drain, ld;
    assign opa = bus.acc_sel ? acc : bus.a;
    assign add_w = {1'b0, opa} + {1'b0, bus.b};
    // top bit of a zero-extended difference is the borrow
    assign sub_ab = {1'b0, opa} - {1'b0, bus.b};
    assign sub_ba = {1'b0, bus.b} - {1'b0, opa};
    assign take = bus.in_valid && bus.in_ready;
    assign drain = bus.out_valid && bus.out_ready;
    always_comb begin
        res = '0;
        c = 1'b0;
        case (bus.op)
            4'd1: {c, res} = sub_ba;
            4'd2: {c, res} = sub_ab;
            4'd3: {c, res} = add_w;
            4'd4: res = opa ^ bus.b;
            4'd5: res = opa | bus.b;
            4'd6: res = opa & bus.b;
            4'd7: res = '1;
            default: res = '0;
        endcase
    end
`ifdef ALU_MUL_EN
    typedef enum logic {IDLE, MUL} state_t;
    state_t state;
    logic [2*WIDTH-1:0] mcand, prod, prod_nxt;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0] cnt;
    logic is_mul, last;
    assign is_mul = bus.op == 4'd8;
    assign last = cnt == CW'(WIDTH - 1);
    assign prod_nxt = prod + (mplier[0] ? mcand : '0);
    assign bus.busy = state == MUL;
    assign bus.in_ready = state == IDLE && (!bus.out_valid || bus.out_ready);
    assign ld = (take && !is_mul) || (state == MUL && last);
    assign fin_res = state == MUL ? prod_nxt[WIDTH-1:0] : res;
    assign fin_c = state == MUL ? |prod_nxt[2*WIDTH-1:WIDTH] : c;
`else
    assign bus.busy = 1'b0;
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign ld = take;
    assign fin_res = res;
    assign fin_c = c;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.result <= '0;
            bus.carry <= 1'b0;
            bus.zero <= 1'b1;
            bus.out_valid <= 1'b0;
            acc <= '0;
`ifdef ALU_MUL_EN
            state <= IDLE;
            mcand <= '0;
            mplier <= '0;
            prod <= '0;
            cnt <= '0;
`endif
        end else begin
            if (drain)
                bus.out_valid <= 1'b0;
            if (ld) begin
                bus.result <= fin_res;
                bus.carry <= fin_c;
                bus.zero <= fin_res == '0;
                bus.out_valid <= 1'b1;
                acc <= fin_res;
            end
`ifdef ALU_MUL_EN
            if (take && is_mul) begin
                mcand <= {{WIDTH{1'b0}}, opa};
                mplier <= bus.b;
                prod <= '0;
                cnt <= '0;
                state <= MUL;
            end else if (state == MUL) begin
                prod <= prod_nxt;
                mcand <= mcand << 1;
                mplier <= mplier >> 1;
                cnt <= cnt + 1'b1;
                if (last)
                    state <= IDLE;
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq; covers the ALU_MUL_EN build when that macro is defined
module tb_alu_seq;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int total = 0;
    int bad = 0;
    logic [W+1:0] sb[$];
    logic [W-1:0] m_acc = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint lx, ly, r;
        logic [63:0] u;
        lx = longint'(x);
        ly = longint'(y);
        case (o)
            4'd1: r = ly - lx;
            4'd2: r = lx - ly;
            4'd3: r = lx + ly;
            4'd4: r = lx ^ ly;
            4'd5: r = lx | ly;
            4'd6: r = lx & ly;
            4'd7: r = (longint'(1) << W) - 1;
`ifdef ALU_MUL_EN
            4'd8: r = lx * ly;
`endif
            default: r = 0;
        endcase
        u = r;
        return {(r < 0) || (r >= (longint'(1) << W)), u[W-1:0]};
    endfunction

    task automatic cyc();
        logic [W+1:0] e;
        logic [W:0] m;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_res", bus.result, e[W-1:0]);
                check("sb_carry", bus.carry, e[W]);
                check("sb_zero", bus.zero, e[W+1]);
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            m = model(bus.op, bus.acc_sel ? m_acc : bus.a, bus.b);
            m_acc = m[W-1:0];
            sb.push_back({m[W-1:0] == '0, m});
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.a = x;
        bus.b = y;
        bus.acc_sel = s;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] r, input logic cy, input logic z);
        check({tag, "_r"}, bus.result, r);
        check({tag, "_c"}, bus.carry, cy);
        check({tag, "_z"}, bus.zero, z);
        check({tag, "_v"}, bus.out_valid, 1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        bus.acc_sel = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_res", bus.result, 0);
        check("rst_carry", bus.carry, 0);
        check("rst_zero", bus.zero, 1);
        check("rst_ov", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_irdy", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        send(4'd2, 8'h0A, 8'h03, 1'b0);
        expect_out("sub_ab", 8'h07, 1'b0, 1'b0);
        send(4'd1, 8'h0A, 8'h03, 1'b0);
        expect_out("sub_ba", 8'hF9, 1'b1, 1'b0);
        send(4'd3, 8'h0A, 8'h03, 1'b0);
        expect_out("add", 8'h0D, 1'b0, 1'b0);
        send(4'd3, 8'hFF, 8'h01, 1'b0);
        expect_out("add_wrap", 8'h00, 1'b1, 1'b1);
        send(4'd3, 8'h77, 8'h05, 1'b1);
        expect_out("acc1", 8'h05, 1'b0, 1'b0);
        send(4'd3, 8'h77, 8'h05, 1'b1);
        expect_out("acc2", 8'h0A, 1'b0, 1'b0);
        cyc();
        bus.out_ready = 1'b0;
        send(4'd5, 8'h0C, 8'h30, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("hold_r", bus.result, 8'h3C);
            check("hold_v", bus.out_valid, 1);
            check("hold_irdy", bus.in_ready, 0);
            cyc();
        end
        bus.out_ready = 1'b1;
        send(4'd6, 8'hF0, 8'h3C, 1'b0);
        expect_out("swap", 8'h30, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            bus.in_valid = $urandom_range(0, 3) != 0;
            bus.op = 4'($urandom_range(0, 15));
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            bus.acc_sel = $urandom_range(0, 1) != 0;
            bus.out_ready = $urandom_range(0, 3) != 0;
            cyc();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && (sb.size() != 0 || bus.out_valid); i++)
            cyc();
        check("drained", sb.size(), 0);
`ifdef ALU_MUL_EN
        send(4'd8, 8'd13, 8'd11, 1'b0);
        for (int i = 0; i < W; i++) begin
            check("mul_busy", bus.busy, 1);
            check("mul_ov", bus.out_valid, 0);
            cyc();
        end
        check("mul_busy_end", bus.busy, 0);
        expect_out("mul1", 8'h8F, 1'b0, 1'b0);
        send(4'd8, 8'h20, 8'h10, 1'b0);
        for (int i = 0; i < W; i++)
            cyc();
        expect_out("mul2", 8'h00, 1'b1, 1'b1);
        send(4'd8, 8'h05, 8'h07, 1'b0);
        repeat (3) cyc();
        rst_n = 1'b0;
        sb.delete();
        m_acc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_ov", bus.out_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_zero", bus.zero, 1);
        check("abort_irdy", bus.in_ready, 1);
        for (int i = 0; i < 2 * W; i++) begin
            check("abort_quiet", bus.out_valid, 0);
            cyc();
        end
        send(4'd3, 8'hAA, 8'h00, 1'b1);
        expect_out("abort_acc", 8'h00, 1'b0, 1'b1);
`else
        send(4'd7, 8'h00, 8'h00, 1'b0);
        expect_out("ones", 8'hFF, 1'b0, 1'b0);
        send(4'd8, 8'h33, 8'h44, 1'b0);
        expect_out("op8_rsv", 8'h00, 1'b0, 1'b1);
        check("op8_busy", bus.busy, 0);
        send(4'd7, 8'h00, 8'h00, 1'b0);
        send(4'd12, 8'h55, 8'h66, 1'b0);
        expect_out("op12_rsv", 8'h00, 1'b0, 1'b1);
        check("op12_busy", bus.busy, 0);
`endif
        for (int i = 0; i < 10 && (sb.size() != 0 || bus.out_valid); i++)
            cyc();
        check("final_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
